// File: rtl/gpio_bank_ctrl_if.sv
// Avalon-MM slave bus bundle for gpio_bank_ctrl: word address, strobes, data and irq.
// master = CPU/interconnect side, slave = the GPIO bank.
interface gpio_bank_ctrl_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/gpio_bank_ctrl.sv
// Memory-mapped GPIO bank: direction/data registers, input synchroniser, edge capture and irq.
// Optional per-pin input debouncer enabled by defining GPIO_DEBOUNCE_EN.
module gpio_bank_ctrl #(
    parameter int WIDTH           = 32,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    gpio_bank_ctrl_if.slave      bus,
    input  logic [WIDTH-1:0]     gpio_i,
    output logic [WIDTH-1:0]     gpio_o,
    output logic [WIDTH-1:0]     gpio_oe
);

    localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [2:0] ADDR_DIR      = 3'd2;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd3;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd4;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd5;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd6;
    localparam logic [2:0] ADDR_OUT_TGL  = 3'd7;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] cond_w;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] clr_w;
    logic [WIDTH-1:0] rise_w;
    logic [WIDTH-1:0] fall_w;
    logic [31:0]      rd_word_w;

    // Stage 0 samples the asynchronous pins; the last stage is the synchronised value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_i};
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic [WIDTH-1:0] deb_w;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_deb
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             deb_q, deb_d;

        // The counter only runs while the pin disagrees with the accepted level.
        always_comb begin
            cnt_d = '0;
            deb_d = deb_q;
            if (sync_w[gi] != deb_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d = sync_w[gi];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
                deb_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                deb_q <= deb_d;
            end
        end

        assign deb_w[gi] = deb_q;
    end

    assign cond_w = deb_w;
`else
    assign cond_w = sync_w;
`endif

    assign wdata_w = bus.writedata[WIDTH-1:0];
    assign rise_w  = cond_w & ~prev_q & rise_en_q;
    assign fall_w  = ~cond_w & prev_q & fall_en_q;

    always_comb begin
        data_out_d = data_out_q;
        dir_d      = dir_q;
        irq_mask_d = irq_mask_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        clr_w      = '0;
        if (bus.write) begin
            case (bus.address)
                ADDR_DATA_OUT: data_out_d = wdata_w;
                ADDR_DIR:      dir_d      = wdata_w;
                ADDR_IRQ_MASK: irq_mask_d = wdata_w;
                ADDR_EDGE_CAP: clr_w      = wdata_w;
                ADDR_RISE_EN:  rise_en_d  = wdata_w;
                ADDR_FALL_EN:  fall_en_d  = wdata_w;
                ADDR_OUT_TGL:  data_out_d = data_out_q ^ wdata_w;
                default:       ;
            endcase
        end
        // New edges are OR-ed in after the clear so a coincident set survives.
        edge_cap_d = (edge_cap_q & ~clr_w) | rise_w | fall_w;
    end

    always_comb begin
        rd_word_w = '0;
        case (bus.address)
            ADDR_DATA_IN:  rd_word_w = 32'(cond_w);
            ADDR_DATA_OUT: rd_word_w = 32'(data_out_q);
            ADDR_DIR:      rd_word_w = 32'(dir_q);
            ADDR_IRQ_MASK: rd_word_w = 32'(irq_mask_q);
            ADDR_EDGE_CAP: rd_word_w = 32'(edge_cap_q);
            ADDR_RISE_EN:  rd_word_w = 32'(rise_en_q);
            ADDR_FALL_EN:  rd_word_w = 32'(fall_en_q);
            default:       rd_word_w = '0;
        endcase
        readdata_d = bus.read ? rd_word_w : readdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            data_out_q <= '0;
            dir_q      <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            readdata_q <= '0;
        end else begin
            prev_q     <= cond_w;
            data_out_q <= data_out_d;
            dir_q      <= dir_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = |(edge_cap_q & irq_mask_q);
    assign gpio_o       = data_out_q;
    assign gpio_oe      = dir_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Self-checking bench for gpio_bank_ctrl (WIDTH=8, SYNC_STAGES=2): directed cases plus
// randomized bus/pin traffic compared every cycle against a behavioural register model.
module tb_gpio_bank_ctrl;
    localparam int WIDTH           = 8;
    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 16;

    logic             clk    = 1'b0;
    logic             reset  = 1'b1;
    logic [WIDTH-1:0] gpio_i = '0;
    logic [WIDTH-1:0] gpio_o;
    logic [WIDTH-1:0] gpio_oe;

    gpio_bank_ctrl_if bus ();

    gpio_bank_ctrl #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cycle, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] m_dout, m_dir, m_mask, m_cap, m_rise, m_fall, m_prev;
    logic [31:0]      m_rdata;
    logic [WIDTH-1:0] m_hist[$];   // pin samples, newest first
    logic [WIDTH-1:0] t_cond, t_sync, t_wd, t_clr;
`ifdef GPIO_DEBOUNCE_EN
    logic [WIDTH-1:0] m_deb;
    int               m_run[WIDTH];  // consecutive cycles sync has disagreed with m_deb
`endif

    function automatic logic [WIDTH-1:0] m_sync();
        return (m_hist.size() >= SYNC_STAGES) ? m_hist[SYNC_STAGES-1] : '0;
    endfunction

    function automatic logic [WIDTH-1:0] m_cond();
`ifdef GPIO_DEBOUNCE_EN
        return m_deb;
`else
        return m_sync();
`endif
    endfunction

    function automatic logic [31:0] m_reg(input logic [2:0] a, input logic [WIDTH-1:0] c);
        case (a)
            3'd0:    return 32'(c);
            3'd1:    return 32'(m_dout);
            3'd2:    return 32'(m_dir);
            3'd3:    return 32'(m_mask);
            3'd4:    return 32'(m_cap);
            3'd5:    return 32'(m_rise);
            3'd6:    return 32'(m_fall);
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_dout = '0; m_dir = '0; m_mask = '0; m_cap = '0;
            m_rise = '0; m_fall = '0; m_prev = '0; m_rdata = '0;
            m_hist.delete();
`ifdef GPIO_DEBOUNCE_EN
            m_deb = '0;
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
`endif
        end else begin
            t_cond = m_cond();
            t_sync = m_sync();
            t_wd   = bus.writedata[WIDTH-1:0];
            if (bus.read) m_rdata = m_reg(bus.address, t_cond);
            t_clr  = (bus.write && bus.address == 3'd4) ? t_wd : '0;
            m_cap  = (m_cap & ~t_clr) | (t_cond & ~m_prev & m_rise) | (~t_cond & m_prev & m_fall);
            m_prev = t_cond;
`ifdef GPIO_DEBOUNCE_EN
            for (int i = 0; i < WIDTH; i++) begin
                if (t_sync[i] != m_deb[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEBOUNCE_CYCLES) begin
                        m_deb[i] = t_sync[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
`endif
            m_hist.push_front(gpio_i);
            if (m_hist.size() > SYNC_STAGES) void'(m_hist.pop_back());
            if (bus.write) begin
                case (bus.address)
                    3'd1: m_dout = t_wd;
                    3'd2: m_dir  = t_wd;
                    3'd3: m_mask = t_wd;
                    3'd5: m_rise = t_wd;
                    3'd6: m_fall = t_wd;
                    3'd7: m_dout = m_dout ^ t_wd;
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        cycle++;
        check("m_readdata", bus.readdata, m_rdata);
        check("m_irq", 32'(bus.irq), 32'(|(m_cap & m_mask)));
        check("m_gpio_o", 32'(gpio_o), 32'(m_dout));
        check("m_gpio_oe", 32'(gpio_oe), 32'(m_dir));
    end

    // ---------------- stimulus ----------------
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.write = 1'b1; bus.address = a; bus.writedata = d;
        @(negedge clk);
        bus.write = 1'b0;
        $display("WR addr=%0d data=0x%08h", a, d);
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.read = 1'b1; bus.address = a;
        @(negedge clk);
        bus.read = 1'b0;
        d = bus.readdata;
        $display("RD addr=%0d data=0x%08h", a, d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] rd;

    initial begin
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        idle(3);
        reset = 1'b0;

        // Reset state
        for (int a = 0; a < 8; a++) begin
            bus_read(3'(a), rd);
            check($sformatf("reset_rd%0d", a), rd, 32'h0);
        end
        check("reset_oe", 32'(gpio_oe), 32'h0);
        check("reset_o", 32'(gpio_o), 32'h0);
        check("reset_irq", 32'(bus.irq), 32'h0);

        // Direction, data and toggle
        bus_write(3'd2, 32'hFFFF_FFF0);
        bus_write(3'd1, 32'h0000_00A5);
        check("dir_oe", 32'(gpio_oe), 32'h0000_00F0);
        check("dout_a5", 32'(gpio_o), 32'h0000_00A5);
        bus_write(3'd7, 32'h0000_000F);
        check("tgl_aa", 32'(gpio_o), 32'h0000_00AA);
        bus_read(3'd1, rd);
        check("rd_dout", rd, 32'h0000_00AA);
        bus_read(3'd7, rd);
        check("rd_tgl", rd, 32'h0);
        bus_write(3'd0, 32'h0000_00FF);
        bus_read(3'd0, rd);
        check("din_ro", rd, 32'h0);

        // Simultaneous read and write returns the pre-write value
        bus.read = 1'b1; bus.write = 1'b1; bus.address = 3'd1; bus.writedata = 32'h3C;
        @(negedge clk);
        bus.read = 1'b0; bus.write = 1'b0;
        $display("RW addr=1 wdata=0x0000003c rdata=0x%08h", bus.readdata);
        check("rw_pre", bus.readdata, 32'h0000_00AA);
        check("rw_post", 32'(gpio_o), 32'h0000_003C);
        idle(2);
        check("rd_hold", bus.readdata, 32'h0000_00AA);

`ifndef GPIO_DEBOUNCE_EN
        // Rising edge on pin 0: DATA_IN after 2 edges, capture/irq after 3
        bus_write(3'd5, 32'h01);
        bus_write(3'd3, 32'h01);
        gpio_i[0] = 1'b1;
        idle(1);
        bus_read(3'd0, rd);
        check("din_t1", rd, 32'h00);
        check("irq_t2", 32'(bus.irq), 32'h0);
        bus_read(3'd0, rd);
        check("din_t2", rd, 32'h01);
        check("irq_t3", 32'(bus.irq), 32'h1);
        bus_read(3'd4, rd);
        check("cap_rise", rd, 32'h01);
        bus_write(3'd4, 32'h01);
        check("irq_w1c", 32'(bus.irq), 32'h0);

        // Falling edge on pin 7 coincident with W1C: set wins
        gpio_i[7] = 1'b1;
        gpio_i[1] = 1'b1;
        idle(4);
        bus_write(3'd6, 32'h80);
        gpio_i[7] = 1'b0;
        idle(2);
        bus_write(3'd4, 32'h80);
        bus_read(3'd4, rd);
        check("set_wins", rd, 32'h80);
        bus_write(3'd4, 32'h80);
        bus_read(3'd4, rd);
        check("cap_clr7", rd, 32'h00);

        // Masked capture on pin 3; pin 1 already high gets no retroactive capture
        bus_write(3'd3, 32'h00);
        bus_write(3'd5, 32'h0A);
        gpio_i[3] = 1'b1;
        idle(4);
        bus_read(3'd4, rd);
        check("cap_bit3", rd, 32'h08);
        check("irq_masked", 32'(bus.irq), 32'h0);
        bus_write(3'd3, 32'h08);
        check("irq_unmask", 32'(bus.irq), 32'h1);
        bus_write(3'd4, 32'h08);
        check("irq_clr3", 32'(bus.irq), 32'h0);
`else
        // Debounce: a 10-cycle glitch is rejected, a long pulse lands 16 cycles after sync
        bus_write(3'd5, 32'h04);
        bus_write(3'd3, 32'h04);
        gpio_i[2] = 1'b1;
        idle(10);
        gpio_i[2] = 1'b0;
        idle(30);
        bus_read(3'd0, rd);
        check("deb_glitch_din", rd, 32'h0);
        check("deb_glitch_irq", 32'(bus.irq), 32'h0);
        gpio_i[2] = 1'b1;
        idle(17);
        bus_read(3'd0, rd);
        check("deb_early", rd, 32'h0);
        bus_read(3'd0, rd);
        check("deb_land", rd, 32'h04);
        idle(2);
        check("deb_irq", 32'(bus.irq), 32'h1);
        bus_write(3'd4, 32'h04);
`endif

        // Randomized traffic; model comparison runs every cycle
        for (int i = 0; i < 1000; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            bus.address   = 3'($urandom_range(0, 7));
            bus.writedata = $urandom();
            bus.read      = (op <= 3) || (op == 8);
            bus.write     = (op >= 4 && op <= 6) || (op == 8);
            if ($urandom_range(0, 3) == 0) gpio_i[$urandom_range(0, WIDTH-1)] ^= 1'b1;
            if (bus.read || bus.write)
                $display("RND rd=%0b wr=%0b addr=%0d wdata=0x%08h gpio_i=0x%02h",
                         bus.read, bus.write, bus.address, bus.writedata, gpio_i);
            if (i == 500) begin
                // Reset lands mid-transfer; nothing of the write may survive
                bus.write = 1'b1; bus.address = 3'd1;
                #2 reset = 1'b1;
                @(negedge clk);
                bus.write = 1'b0; bus.read = 1'b0;
                idle(1);
                reset = 1'b0;
                check("midreset_o", 32'(gpio_o), 32'h0);
                check("midreset_rd", bus.readdata, 32'h0);
            end else begin
                @(negedge clk);
            end
        end
        bus.read = 1'b0; bus.write = 1'b0;
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gpio_bank_ctrl.md
Name: gpio_bank_ctrl

Overview:
- Parametrised memory-mapped GPIO bank with one Avalon-MM slave register interface. Replaces the separate direction, read and write PIO triplets per bank.
- Adds input synchronisation, per-pin edge capture with rising/falling select, maskable interrupt, and atomic toggle of outputs.
- The tristate buffer stays in the top level. This block drives gpio_o and gpio_oe and samples gpio_i.

Parameters:
- WIDTH, 32, number of pins in the bank (1..32); registers zero-extended to 32 bits on read.
- SYNC_STAGES, 2, flip-flop stages on gpio_i (2..4).
- DEBOUNCE_CYCLES, 16, stable cycles required before the debounced value changes (only with GPIO_DEBOUNCE_EN).

Ports:
- clk  in  1  system clock (clk25 domain)
- reset  in  1  asynchronous, active-high reset
- address  in  3  word address
- read  in  1  read strobe
- write  in  1  write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  level interrupt, active high
- gpio_i  in  WIDTH  pin input (asynchronous)
- gpio_o  out  WIDTH  pin output value
- gpio_oe  out  WIDTH  pin output enable, 1 = drive

Behaviour:
- Reset (async, active-high):
  - DATA_OUT, DIR, IRQ_MASK, EDGE_CAP, RISE_EN, FALL_EN, sync chain, prev and readdata all go to 0.
  - Resulting outputs: gpio_oe=0 (all pins inputs), gpio_o=0, irq=0.
  - Reset mid-transfer aborts the transfer; no partial register update.
- Register map (word address):
  - 0 DATA_IN: RO, conditioned input value.
  - 1 DATA_OUT: RW.
  - 2 DIR: RW, 1 = output.
  - 3 IRQ_MASK: RW.
  - 4 EDGE_CAP: read; write-1-to-clear.
  - 5 RISE_EN: RW.
  - 6 FALL_EN: RW.
  - 7 OUT_TGL: WO; DATA_OUT ^= writedata; reads return 0.
- Writes:
  - Take effect on the clock edge where write=1; only writedata[WIDTH-1:0] is used.
  - Writes to address 0 are ignored.
- Reads:
  - Fixed latency 1: readdata is valid the cycle after read=1.
  - readdata holds its last value while read=0.
  - Bits [31:WIDTH] always read 0.
  - read and write asserted together: the write executes, and readdata returns the pre-write value.
- Outputs: gpio_o=DATA_OUT, gpio_oe=DIR, both direct from registers (no extra latency).
- Input path:
  - gpio_i passes through SYNC_STAGES flops to give sync.
  - cond = sync, or the debounced value when GPIO_DEBOUNCE_EN is defined.
  - DATA_IN = cond. The pin is sampled regardless of DIR, so output pins read back their driven level.
- Edge detect:
  - prev <= cond every cycle.
  - rise = cond & ~prev & RISE_EN; fall = ~cond & prev & FALL_EN.
  - EDGE_CAP <= (EDGE_CAP & ~clr) | rise | fall.
  - If a set and a W1C clear of the same bit hit the same cycle, set wins.
- Latency:
  - Pin change to DATA_IN update: SYNC_STAGES cycles.
  - Pin change to EDGE_CAP bit and irq: SYNC_STAGES+1 cycles.
- irq = |(EDGE_CAP & IRQ_MASK), from registers. irq stays high until every masked captured bit is cleared or masked off.
- Enabling RISE_EN/FALL_EN does not retroactively capture edges; only transitions after the enable write are captured.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - Per-pin counter of width $clog2(DEBOUNCE_CYCLES+1), reset to 0; the debounced value deb also resets to 0.
  - While sync==deb the counter is held at 0.
  - While they differ the counter increments; on reaching DEBOUNCE_CYCLES-1, deb takes sync and the counter clears.
  - Any return to sync==deb before then clears the counter.
  - Added latency: DEBOUNCE_CYCLES cycles.
- Undefined: no counters; cond = sync; timing as above.

Test Plan (WIDTH=8, SYNC_STAGES=2, debounce off unless stated):
- Reset, then read addresses 0-7 -> all read 0x00000000; gpio_oe=0x00, gpio_o=0x00, irq=0.
- Write DIR=0xF0, DATA_OUT=0xA5, then OUT_TGL=0x0F -> gpio_oe=0xF0; gpio_o=0xA5 then 0xAA; read addr 1 returns 0x000000AA; read addr 7 returns 0.
- RISE_EN=0x01, IRQ_MASK=0x01, gpio_i[0] 0->1 at cycle t:
  - DATA_IN[0]=1 from t+2; EDGE_CAP=0x01 and irq=1 from t+3.
  - Write 0x01 to addr 4 -> EDGE_CAP=0, irq=0 next cycle.
- FALL_EN=0x80, gpio_i[7] 1->0 on the same cycle a W1C of bit 7 lands -> EDGE_CAP[7] remains 1 (set wins).
- Edge captured on bit 3 with IRQ_MASK=0 -> irq=0; write IRQ_MASK=0x08 -> irq=1 the next cycle.
- GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=16:
  - gpio_i[2] glitch high for 10 cycles -> DATA_IN[2] stays 0, no capture.
  - Held high for 20 cycles -> DATA_IN[2]=1 exactly 16 cycles after sync rises.
